// File: rtl/line_window_gen.sv
// KxK sliding-window generator: chained line buffers feed a KxK shift register.
// Only windows lying fully inside the frame on the stride grid are flagged valid.
module line_window_gen #(
   parameter int IMG_Width  = 5,
   parameter int IMG_Height = 5,
   parameter int Datawidth  = 8,
   parameter int K          = 3,
   parameter int STRIDE     = 1
) (
   input  logic                            CLK,
   input  logic                            CLR,
   input  logic [Datawidth-1:0]            In,
   input  logic                            Valid_IN,
   output logic [K*K*Datawidth-1:0]        Win,
   output logic                            Valid_OUT,
   output logic [$clog2(IMG_Height)-1:0]   Out_Row,
   output logic [$clog2(IMG_Width)-1:0]    Out_Col,
   output logic                            Frame_Done
);

   localparam int DW = Datawidth;
   localparam int CW = $clog2(IMG_Width);
   localparam int RW = $clog2(IMG_Height);
   localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_Width - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_Height - 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
   localparam logic [SW-1:0] PH_LAST   = SW'(STRIDE - 1);

   logic [CW-1:0]        col_q, col_d;
   logic [RW-1:0]        row_q, row_d;
   logic [SW-1:0]        cph_q, cph_d;
   logic [SW-1:0]        rph_q, rph_d;
   logic [K*K*DW-1:0]    win_q, win_d;
   logic                 valid_q, valid_d;
   logic [RW-1:0]        orow_q, orow_d;
   logic [CW-1:0]        ocol_q, ocol_d;
   logic                 done_q, done_d;

   logic [DW-1:0]        lb_q [K-1][IMG_Width];
   logic [DW-1:0]        tap  [K-1];
   logic                 accept;
   logic                 col_hit;
   logic                 row_hit;

   assign accept = Valid_IN & ~CLR;

   // tap[j] is the pixel from j+1 lines earlier in the column being accepted
   always_comb begin
      for (int j = 0; j < K-1; j++) begin
         tap[j] = lb_q[j][col_q];
      end
   end

   // Line-buffer RAM: read-before-write at the current column, no reset needed
   always_ff @(posedge CLK) begin
      if (accept) begin
         lb_q[0][col_q] <= In;
         for (int j = 1; j < K-1; j++) begin
            lb_q[j][col_q] <= tap[j-1];
         end
      end
   end

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      cph_d   = cph_q;
      rph_d   = rph_q;
      win_d   = win_q;
      orow_d  = orow_q;
      ocol_d  = ocol_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      col_hit = (col_q >= COL_FIRST) && (cph_q == '0);
      row_hit = (row_q >= ROW_FIRST) && (rph_q == '0);

      if (Valid_IN) begin
         valid_d = col_hit && row_hit;
         done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
         orow_d  = row_q;
         ocol_d  = col_q;

         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K-1; c++) begin
               win_d[(r*K+c)*DW +: DW] = win_q[(r*K+c+1)*DW +: DW];
            end
         end
         win_d[(K*K-1)*DW +: DW] = In;
         for (int r = 0; r < K-1; r++) begin
            win_d[(r*K+K-1)*DW +: DW] = tap[K-2-r];
         end

         // Phase counters track (pos-(K-1)) mod STRIDE once pos reaches K-1
         if (col_q == COL_LAST) begin
            col_d = '0;
            cph_d = '0;
            if (row_q == ROW_LAST) begin
               row_d = '0;
               rph_d = '0;
            end else begin
               row_d = row_q + RW'(1);
               if (row_q >= ROW_FIRST) begin
                  rph_d = (rph_q == PH_LAST) ? '0 : rph_q + SW'(1);
               end else begin
                  rph_d = '0;
               end
            end
         end else begin
            col_d = col_q + CW'(1);
            if (col_q >= COL_FIRST) begin
               cph_d = (cph_q == PH_LAST) ? '0 : cph_q + SW'(1);
            end else begin
               cph_d = '0;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         col_q   <= '0;
         row_q   <= '0;
         cph_q   <= '0;
         rph_q   <= '0;
         win_q   <= '0;
         valid_q <= 1'b0;
         orow_q  <= '0;
         ocol_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         cph_q   <= cph_d;
         rph_q   <= rph_d;
         win_q   <= win_d;
         valid_q <= valid_d;
         orow_q  <= orow_d;
         ocol_q  <= ocol_d;
         done_q  <= done_d;
      end
   end

   assign Win        = win_q;
   assign Valid_OUT  = valid_q;
   assign Out_Row    = orow_q;
   assign Out_Col    = ocol_q;
   assign Frame_Done = done_q;

endmodule

// File: doc/line_window_gen.md
Name: line_window_gen

Overview:
- Parametrised KxK sliding-window generator for the convolution datapath.
- Accepts a raster-scan pixel stream and emits the full KxK neighbourhood as one flattened bus.
- Successor to the fixed 3x3 line-buffer kernel:
  - kernel size and stride are generic;
  - frame geometry is tracked with row/column counters;
  - Valid_OUT marks only windows that lie fully inside the image (no edge/wrap garbage);
  - the window position and an end-of-frame pulse are reported.

Parameters:
- IMG_Width, 5, pixels per line (>= K)
- IMG_Height, 5, lines per frame (>= K)
- Datawidth, 8, bits per pixel
- K, 3, kernel size, 2..7
- STRIDE, 1, window step in both directions, 1..K

Ports:
- CLK  input  1  clock; all logic on rising edge
- CLR  input  1  synchronous active-high reset
- In  input  Datawidth  pixel, raster order
- Valid_IN  input  1  In is valid this cycle; no backpressure
- Win  output  K*K*Datawidth  window, element (r,c) at bits [(r*K+c)*Datawidth +: Datawidth]; r=0 oldest row, c=0 leftmost column
- Valid_OUT  output  1  Win/Out_Row/Out_Col hold a new valid window
- Out_Row  output  clog2(IMG_Height)  image row of window bottom-right pixel
- Out_Col  output  clog2(IMG_Width)  image column of window bottom-right pixel
- Frame_Done  output  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Reset:
  - CLR=1 at a clock edge clears row/col counters, all K*K window registers, Valid_OUT, Out_Row, Out_Col and Frame_Done to 0.
  - Line-buffer RAM contents are not cleared; they are don't-care because they are gated by the counters.
  - CLR has priority over Valid_IN: a pixel presented in a CLR cycle is discarded.
  - Reset mid-frame: the next accepted pixel is treated as (0,0).
- Accept: a pixel is accepted on each edge with Valid_IN=1 and CLR=0. Cycles with Valid_IN=0 change nothing; Win, Out_Row and Out_Col hold.
- Storage:
  - K-1 line buffers, each IMG_Width deep, are chained; buffer j delays by one line the data entering it.
  - All line buffers advance only on accept.
- Window shift on accept:
  - column c takes column c+1 for c < K-1;
  - new column K-1 takes row K-1 = In and row r = the same-column pixel from (K-1-r) lines earlier.
- Counters:
  - col increments on accept and wraps from IMG_Width-1 to 0; on wrap, row increments.
  - row wraps from IMG_Height-1 to 0.
  - Counters refer to the pixel being accepted.
- Valid_OUT (registered, latency 1):
  - Set in the cycle after accepting pixel (row,col) iff row >= K-1, col >= K-1, (row-(K-1)) mod STRIDE == 0 and (col-(K-1)) mod STRIDE == 0.
  - Otherwise cleared. It is a pulse per qualifying accept, not a level.
  - When set, Win holds rows row-K+1..row and cols col-K+1..col; Out_Row=row, Out_Col=col.
- Edges: a window never spans a line boundary or a frame boundary.
  - Columns 0..K-2 of every row are suppressed.
  - Rows 0..K-2 of every frame are suppressed, including stale data from the previous frame.
- Frame_Done: set the cycle after accepting (IMG_Height-1, IMG_Width-1); cleared otherwise. It may coincide with Valid_OUT.
- Windows per frame: ((IMG_Height-K)/STRIDE+1) * ((IMG_Width-K)/STRIDE+1), integer division.
- Back-to-back frames need no idle cycles; the next frame starts at (0,0) on the cycle after the last pixel.
- Mod-STRIDE checks use per-axis phase counters, not dividers.

Test Plan:
- W=H=5, K=3, STRIDE=1, continuous pixels value = row*5+col+1 -> exactly 9 Valid_OUT pulses.
  - First pulse follows pixel 13: Win = 1,2,3,6,7,8,11,12,13; Out_Row=2, Out_Col=2.
  - Last pulse follows pixel 25; Frame_Done coincides with it.
- Same stream: no Valid_OUT after pixels at (3,0), (3,1), (4,0) or (4,1), i.e. no wrap-around windows.
- Same frame with random Valid_IN gaps of 0..4 cycles -> identical 9-window sequence; Win stable during gaps; Valid_OUT never asserted in a cycle following Valid_IN=0.
- W=H=6, K=3, STRIDE=2 -> 4 windows at (row,col) = (2,2), (2,4), (4,2), (4,4); first Win = 1,2,3,7,8,9,13,14,15.
- W=7, H=5, K=5, STRIDE=1 -> 3 windows.
  - First after pixel 33: R(0,0)=1, R(4,4)=33.
  - Second: R(0,0)=2, R(4,4)=34.
- Two back-to-back frames, then CLR asserted together with Valid_IN at pixel (3,2) of a third frame:
  - frames 1 and 2 each give 9 identical windows and one Frame_Done pulse;
  - after CLR all outputs are 0; the pixel is dropped; the restarted frame gives 9 correct windows.
